// File: rtl/l2_cache_control_if.sv
// l2_cache_control_if: L1 request, datapath status, pmem handshake and array strobe bundle
interface l2_cache_control_if #(parameter int WAY_W = 2);
  logic             mem_read;
  logic             mem_write;
  logic             mem_resp;
  logic             hit;
  logic [WAY_W-1:0] hit_way;
  logic [WAY_W-1:0] lru_way;
  logic             victim_valid;
  logic             victim_dirty;
  logic             pmem_read;
  logic             pmem_write;
  logic             pmem_resp;
  logic             addr_sel;
  logic [WAY_W-1:0] way_sel;
  logic             data_load;
  logic             data_src_sel;
  logic             tag_load;
  logic             valid_set;
  logic             dirty_set;
  logic             dirty_clr;
  logic             lru_load;
  logic [WAY_W-1:0] lru_mru;
  modport slave (
    input  mem_read, mem_write, hit, hit_way, lru_way, victim_valid, victim_dirty, pmem_resp,
    output mem_resp, pmem_read, pmem_write, addr_sel, way_sel, data_load, data_src_sel,
           tag_load, valid_set, dirty_set, dirty_clr, lru_load, lru_mru
  );
  modport master (
    output mem_read, mem_write, hit, hit_way, lru_way, victim_valid, victim_dirty, pmem_resp,
    input  mem_resp, pmem_read, pmem_write, addr_sel, way_sel, data_load, data_src_sel,
           tag_load, valid_set, dirty_set, dirty_clr, lru_load, lru_mru
  );
endinterface

// File: rtl/l2_cache_control.sv
// l2_cache_control: 4-way L2 control FSM sequencing compare, dirty writeback and line fill
module l2_cache_control #(
  parameter int WAYS  = 4,
  parameter int WAY_W = 2
) (
  input logic               clk,
  input logic               rst,
  l2_cache_control_if.slave bus
);
  if (WAYS != 4) begin : g_ways_check
    $error("l2_cache_control supports only WAYS=4");
  end
  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] COMPARE   = 2'd1;
  localparam logic [1:0] WRITEBACK = 2'd2;
  localparam logic [1:0] FILL      = 2'd3;
  logic [1:0]       state_q, state_d;
  logic [WAY_W-1:0] victim_q, victim_d;
  logic req, cmp_hit, cmp_miss, in_wb, in_fill, fill_done;
  assign req       = bus.mem_read | bus.mem_write;
  assign cmp_hit   = (state_q == COMPARE) & req & bus.hit;
  assign cmp_miss  = (state_q == COMPARE) & req & ~bus.hit;
  assign in_wb     = state_q == WRITEBACK;
  assign in_fill   = state_q == FILL;
  assign fill_done = in_fill & bus.pmem_resp;
  assign bus.mem_resp     = cmp_hit;
  assign bus.lru_load     = cmp_hit;
  assign bus.lru_mru      = cmp_hit ? bus.hit_way : '0;
  assign bus.way_sel      = cmp_hit ? bus.hit_way : (in_wb | in_fill) ? victim_q : '0;
  assign bus.pmem_write   = in_wb;
  assign bus.pmem_read    = in_fill;
  assign bus.addr_sel     = in_wb;
  assign bus.data_load    = (cmp_hit & bus.mem_write) | fill_done;
  assign bus.data_src_sel = fill_done;
  assign bus.tag_load     = fill_done;
  assign bus.valid_set    = fill_done;
  assign bus.dirty_set    = cmp_hit & bus.mem_write;
  assign bus.dirty_clr    = (in_wb | in_fill) & bus.pmem_resp;
  // next state and victim capture; the victim is frozen from miss detection until the fill lands
  always_comb begin
    victim_d = cmp_miss ? bus.lru_way : victim_q;
    state_d  = (state_q == IDLE)    ? (req ? COMPARE : IDLE) :
               (state_q == COMPARE) ? (cmp_miss ? ((bus.victim_valid & bus.victim_dirty) ? WRITEBACK : FILL) : IDLE) :
               in_wb                ? (bus.pmem_resp ? FILL : WRITEBACK) :
                                      (bus.pmem_resp ? COMPARE : FILL);
  end
  // state and victim registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      victim_q <= '0;
    end else begin
      state_q  <= state_d;
      victim_q <= victim_d;
    end
  end
endmodule

// File: tb/tb_l2_cache_control.sv
// tb_l2_cache_control: table, directed and randomized transaction checks of the L2 control FSM
module tb_l2_cache_control;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int nvec = 0;
  int nerr = 0;
  always #5 clk = ~clk;
  l2_cache_control_if #(.WAY_W(2)) b ();
  l2_cache_control #(.WAYS(4), .WAY_W(2)) dut (.clk(clk), .rst(rst), .bus(b));
  typedef struct packed {
    logic       mem_resp, pmem_read, pmem_write, addr_sel;
    logic [1:0] way_sel;
    logic       data_load, data_src_sel, tag_load, valid_set, dirty_set, dirty_clr, lru_load;
    logic [1:0] lru_mru;
  } out_t;
  typedef struct {
    bit       rd, wr;
    bit [1:0] hw;
    out_t     exp;
  } vec_t;
  function automatic out_t snap();
    return {b.mem_resp, b.pmem_read, b.pmem_write, b.addr_sel, b.way_sel, b.data_load,
            b.data_src_sel, b.tag_load, b.valid_set, b.dirty_set, b.dirty_clr, b.lru_load, b.lru_mru};
  endfunction
  function automatic out_t hit_exp(bit wr, bit [1:0] w);
    out_t e = '0;
    e.mem_resp = 1; e.lru_load = 1; e.lru_mru = w; e.way_sel = w;
    e.data_load = wr; e.dirty_set = wr;
    return e;
  endfunction
  function automatic out_t wb_exp(bit [1:0] w, bit last);
    out_t e = '0;
    e.pmem_write = 1; e.addr_sel = 1; e.way_sel = w; e.dirty_clr = last;
    return e;
  endfunction
  function automatic out_t fill_exp(bit [1:0] w, bit last);
    out_t e = '0;
    e.pmem_read = 1; e.way_sel = w;
    e.data_load = last; e.data_src_sel = last; e.tag_load = last; e.valid_set = last; e.dirty_clr = last;
    return e;
  endfunction
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(string n, out_t e);
    out_t a;
    @(negedge clk);
    a = snap();
    nvec++;
    if (a !== e) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask
  task automatic idle_inputs();
    b.mem_read = 0; b.mem_write = 0; b.hit = 0; b.hit_way = 0; b.lru_way = 0;
    b.victim_valid = 0; b.victim_dirty = 0; b.pmem_resp = 0;
  endtask
  // One full L1 request, expectations derived from the transaction's own parameters.
  task automatic run_req(bit rd, bit wr, bit h, bit [1:0] hw, bit [1:0] lw, bit vv, bit vd,
                         int wb_lat, int fill_lat, bit drop, bit toggle, bit noisy);
    bit w = wr;
    next_cycle();
    b.mem_read = rd; b.mem_write = wr; b.hit = h; b.hit_way = hw; b.lru_way = lw;
    b.victim_valid = vv; b.victim_dirty = vd; b.pmem_resp = noisy ? 1'($urandom) : 1'b0;
    chk("idle_req", '0);
    next_cycle();
    b.pmem_resp = noisy ? 1'($urandom) : 1'b0;
    if (h) begin
      chk("cmp_hit", hit_exp(w, hw));
      next_cycle();
      idle_inputs();
      chk("after_hit", '0);
      return;
    end
    chk("cmp_miss", '0);
    if (vv && vd) begin
      for (int k = 1; k <= wb_lat; k++) begin
        next_cycle();
        b.hit = 0; b.pmem_resp = (k == wb_lat);
        b.lru_way = toggle ? lw ^ 2'd2 : lw;
        chk("writeback", wb_exp(lw, k == wb_lat));
      end
    end
    for (int k = 1; k <= fill_lat; k++) begin
      next_cycle();
      b.hit = 0; b.pmem_resp = (k == fill_lat);
      b.lru_way = toggle ? lw ^ 2'd2 : lw;
      if (drop) begin b.mem_read = 0; b.mem_write = 0; end
      chk("fill", fill_exp(lw, k == fill_lat));
    end
    next_cycle();
    b.pmem_resp = noisy ? 1'($urandom) : 1'b0;
    b.hit = 1; b.hit_way = lw;
    if (drop) chk("recmp_dropped", '0);
    else chk("recmp_hit", hit_exp(w, lw));
    next_cycle();
    idle_inputs();
    chk("after_req", '0);
  endtask
  vec_t tbl[4];
  initial begin
    out_t e;
    idle_inputs();
    tbl[0] = '{1, 0, 2'd2, hit_exp(0, 2'd2)};
    tbl[1] = '{0, 1, 2'd1, hit_exp(1, 2'd1)};
    tbl[2] = '{1, 1, 2'd3, hit_exp(1, 2'd3)};
    tbl[3] = '{1, 0, 2'd0, hit_exp(0, 2'd0)};
    next_cycle();
    next_cycle();
    rst = 0;
    chk("reset", '0);
    foreach (tbl[i]) begin
      next_cycle();
      b.mem_read = tbl[i].rd; b.mem_write = tbl[i].wr; b.hit = 1; b.hit_way = tbl[i].hw;
      chk("tbl_idle", '0);
      next_cycle();
      chk($sformatf("tbl_hit%0d", i), tbl[i].exp);
      next_cycle();
      idle_inputs();
      chk("tbl_after", '0);
    end
    // clean read miss, victim way 3, fill takes 5 cycles
    run_req(1, 0, 0, 2'd0, 2'd3, 1, 0, 0, 5, 0, 0, 0);
    // dirty write miss, victim way 0, writeback 3 cycles, fill 4, lru_way moves to 2 meanwhile
    run_req(0, 1, 0, 2'd0, 2'd0, 1, 1, 3, 4, 0, 1, 0);
    // request dropped during fill: line installed, no response
    run_req(1, 0, 0, 2'd0, 2'd1, 0, 1, 0, 3, 1, 0, 0);
    // reset in the middle of a writeback
    next_cycle();
    b.mem_read = 1; b.lru_way = 2'd1; b.victim_valid = 1; b.victim_dirty = 1;
    chk("rst_seq_idle", '0);
    next_cycle();
    chk("rst_seq_cmp", '0);
    next_cycle();
    chk("rst_seq_wb", wb_exp(2'd1, 0));
    next_cycle();
    rst = 1;
    next_cycle();
    rst = 0;
    idle_inputs();
    chk("rst_flush", '0);
    run_req(1, 0, 1, 2'd2, 2'd0, 0, 0, 0, 0, 0, 0, 0);
    // randomized transactions with stray pmem_resp pulses in idle/compare
    for (int i = 0; i < 40; i++) begin
      bit rd = 1'($urandom);
      bit wr = ~rd | 1'($urandom);
      run_req(rd, wr, ($urandom_range(0, 2) == 0), 2'($urandom), 2'($urandom), 1'($urandom), 1'($urandom),
              $urandom_range(1, 4), $urandom_range(1, 4), ($urandom_range(0, 4) == 0), 1'($urandom), 1);
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
